// File: rtl/macc_pkg.sv
// Shared definitions for the multiply-add / multiply-accumulate pipeline:
// mode encodings, guard-bit count for the wide adder and the input-stage bound.
package macc_pkg;

  localparam logic [1:0] MODE_MADD     = 2'b00;
  localparam logic [1:0] MODE_MSUB     = 2'b01;
  localparam logic [1:0] MODE_MACC     = 2'b10;
  localparam logic [1:0] MODE_MACC_SUB = 2'b11;

  // Extra bits above ACC_WIDTH so every sum/difference is exact before range checks
  localparam int unsigned GUARD_BITS = 2;

  // Largest supported input register depth
  localparam int unsigned MAX_IN_STAGES = 4;

endpackage

// File: rtl/macc_delay_line.sv
// WIDTH x DEPTH register chain with synchronous active-high reset.
// DEPTH=0 degenerates to a wire passthrough.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, clears every stage
//   din  - data entering the chain
//   dout - data leaving the chain, DEPTH cycles later
module macc_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_regs
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift register; stage 0 captures din
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= din;
          for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/multiplier_accumulate_pipe.sv
// Pipelined multiply-add / multiply-accumulate unit with overflow reporting.
// Operands travel through IN_STAGES input registers, then a single result
// register computes c +/- a*b (MADD/MSUB) or acc +/- a*b (MACC/MACC_SUB).
// Optional feature macro: MACC_SATURATE_EN -- clamp res on overflow instead
// of wrapping modulo 2^ACC_WIDTH.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   in_valid  - qualifies a, b, c, mode, acc_clr
//   a, b      - multiplicand, multiplier
//   c         - addend / accumulator seed
//   mode      - 00 MADD, 01 MSUB, 10 MACC, 11 MACC_SUB
//   acc_clr   - in MACC modes, seed from c rather than the running result
//   out_valid - res/ovf valid this cycle
//   res       - result / accumulator
//   ovf       - this operation's exact result did not fit ACC_WIDTH
module multiplier_accumulate_pipe
  import macc_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned C_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned IN_STAGES = 2,
  parameter int unsigned SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic [C_WIDTH-1:0]   c,
  input  logic [1:0]           mode,
  input  logic                 acc_clr,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] res,
  output logic                 ovf
);

  localparam int unsigned EW = ACC_WIDTH + GUARD_BITS;
  localparam int unsigned BW = 1 + 1 + 2 + C_WIDTH + B_WIDTH + A_WIDTH;

  localparam logic [ACC_WIDTH-1:0] RES_MAX = (SIGNED != 0) ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : '1;
  localparam logic [ACC_WIDTH-1:0] RES_MIN = (SIGNED != 0) ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : '0;

  // Parameter legality
  generate
    if ((ACC_WIDTH < A_WIDTH + B_WIDTH) || (ACC_WIDTH < C_WIDTH)) begin : g_bad_acc_width
      $error("multiplier_accumulate_pipe: ACC_WIDTH too small for operands");
    end
    if (IN_STAGES > MAX_IN_STAGES) begin : g_bad_in_stages
      $error("multiplier_accumulate_pipe: IN_STAGES out of range 0..4");
    end
  endgenerate

  logic [BW-1:0]      bundle_in;
  logic [BW-1:0]      bundle_d;
  logic               v_d;
  logic               clr_d;
  logic [1:0]         mode_d;
  logic [C_WIDTH-1:0] c_d;
  logic [B_WIDTH-1:0] b_d;
  logic [A_WIDTH-1:0] a_d;

  // All operation fields share one delay line so they stay aligned
  assign bundle_in = {in_valid, acc_clr, mode, c, b, a};

  macc_delay_line #(
    .WIDTH (BW),
    .DEPTH (IN_STAGES)
  ) u_in_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (bundle_in),
    .dout (bundle_d)
  );

  assign {v_d, clr_d, mode_d, c_d, b_d, a_d} = bundle_d;

  logic [EW-1:0]        a_ext;
  logic [EW-1:0]        b_ext;
  logic [EW-1:0]        c_ext;
  logic [EW-1:0]        acc_ext;
  logic [EW-1:0]        base;
  logic [EW-1:0]        prod;
  logic [EW-1:0]        sum;
  logic                 accumulate;
  logic                 subtract;
  logic                 ovf_c;
  logic [ACC_WIDTH-1:0] res_c;

  // Extension, wide add/subtract and range check for the final stage
  always_comb begin
    a_ext      = '0;
    b_ext      = '0;
    c_ext      = '0;
    acc_ext    = '0;
    base       = '0;
    prod       = '0;
    sum        = '0;
    ovf_c      = 1'b0;
    res_c      = '0;
    accumulate = (mode_d == MODE_MACC) || (mode_d == MODE_MACC_SUB);
    subtract   = (mode_d == MODE_MSUB) || (mode_d == MODE_MACC_SUB);

    if (SIGNED != 0) begin
      a_ext   = EW'($signed(a_d));
      b_ext   = EW'($signed(b_d));
      c_ext   = EW'($signed(c_d));
      acc_ext = EW'($signed(res));
    end else begin
      a_ext   = EW'(a_d);
      b_ext   = EW'(b_d);
      c_ext   = EW'(c_d);
      acc_ext = EW'(res);
    end

    // Low EW bits of the product are exact in both signednesses
    prod = a_ext * b_ext;
    base = (accumulate && !clr_d) ? acc_ext : c_ext;
    sum  = subtract ? (base - prod) : (base + prod);

    // Signed: bits above the sign must replicate it; unsigned: bits above must be 0
    if (SIGNED != 0) begin
      ovf_c = !((&sum[EW-1:ACC_WIDTH-1]) || !(|sum[EW-1:ACC_WIDTH-1]));
    end else begin
      ovf_c = |sum[EW-1:ACC_WIDTH];
    end

`ifdef MACC_SATURATE_EN
    // Top guard bit gives the overflow direction
    if (ovf_c) res_c = sum[EW-1] ? RES_MIN : RES_MAX;
    else       res_c = sum[ACC_WIDTH-1:0];
`else
    res_c = sum[ACC_WIDTH-1:0];
`endif
  end

  // Result register; bubbles leave res/ovf (and hence the accumulator) untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= v_d;
      if (v_d) begin
        res <= res_c;
        ovf <= ovf_c;
      end
    end
  end

endmodule
